mc_controlunit: RTL and testbench

Multicycle control unit for the ARM processor: a Moore FSM that sequences each instruction through fetch, decode, and execute steps over 3–5 clocks. It drives the shared-memory, single-ALU multicycle datapath. It keeps the NZCV status register and evaluates the ARM condition field once per instruction. Width of the ALU control bus and the flag reset value are parameters.

---
 rtl/mc_ctrl_pkg.sv | 120 ++++++++++++
 rtl/mc_controlunit_cond_check.sv | 35 +++
 rtl/mc_controlunit.sv | 162 ++++++++++++++++
 tb/tb_mc_controlunit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned COND_W  = 4;
   localparam int unsigned FLAGS_W = 4;

   // FSM state encodings (visible on the State debug port)
   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_e;

   // Instruction Op field
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field (Funct[4:1])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b100;

   // ARM condition codes
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   // Flag-write masks: bit 1 = N,Z ; bit 0 = C,V
   localparam logic [1:0] FLAGW_NONE = 2'b00;
   localparam logic [1:0] FLAGW_NZ   = 2'b10;
   localparam logic [1:0] FLAGW_ALL  = 2'b11;

   // Result mux selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU B-operand selects
   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // Decoded data-processing controls
   typedef struct packed {
      logic [2:0] alu_op;
      logic [1:0] flag_w;
      logic       no_write;
   } alu_dec_t;

   // Map {cmd, S} onto ALU op, flag-write mask and result suppression
   function automatic alu_dec_t alu_decode(input logic [3:0] cmd, input logic s);
      alu_dec_t d;
      d.alu_op   = ALU_ADD;
      d.flag_w   = FLAGW_NONE;
      d.no_write = 1'b0;
      case (cmd)
         CMD_ADD: begin
            d.alu_op = ALU_ADD;
            if (s) d.flag_w = FLAGW_ALL;
         end
         CMD_SUB: begin
            d.alu_op = ALU_SUB;
            if (s) d.flag_w = FLAGW_ALL;
         end
         CMD_AND: begin
            d.alu_op = ALU_AND;
            if (s) d.flag_w = FLAGW_NZ;
         end
         CMD_ORR: begin
            d.alu_op = ALU_ORR;
            if (s) d.flag_w = FLAGW_NZ;
         end
         CMD_EOR: begin
            d.alu_op = ALU_EOR;
            if (s) d.flag_w = FLAGW_NZ;
         end
         CMD_CMP: begin
            if (s) begin
               d.alu_op   = ALU_SUB;
               d.flag_w   = FLAGW_ALL;
               d.no_write = 1'b1;
            end
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mc_controlunit_cond_check.sv
// ARM condition-field evaluation against stored NZCV flags.
module cond_check
   import mc_ctrl_pkg::*;
(
   input  logic [COND_W-1:0]  cond_i,
   input  logic [FLAGS_W-1:0] nzcv_i,
   output logic               cond_ex_o
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv_i;

   // Condition truth table; 1111 behaves as always-execute
   always_comb begin
      cond_ex_o = 1'b0;
      case (cond_i)
         COND_EQ: cond_ex_o = z;
         COND_NE: cond_ex_o = ~z;
         COND_CS: cond_ex_o = c;
         COND_CC: cond_ex_o = ~c;
         COND_MI: cond_ex_o = n;
         COND_PL: cond_ex_o = ~n;
         COND_VS: cond_ex_o = v;
         COND_VC: cond_ex_o = ~v;
         COND_HI: cond_ex_o = c & ~z;
         COND_LS: cond_ex_o = ~c | z;
         COND_GE: cond_ex_o = (n == v);
         COND_LT: cond_ex_o = (n != v);
         COND_GT: cond_ex_o = ~z & (n == v);
         COND_LE: cond_ex_o = z | (n != v);
         default: cond_ex_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controlunit.sv
// Multicycle ARM control unit: Moore sequencer, ALU decoder, NZCV register.
module mc_controlunit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUC_W     = 3,
   parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       Instr,
   input  logic [3:0]        ALUFlags,
   output logic              PCWrite,
   output logic              AdrSrc,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              RegWrite,
   output logic [1:0]        ResultSrc,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [ALUC_W-1:0] ALUControl,
   output logic [1:0]        ImmSrc,
   output logic [1:0]        RegSrc,
   output logic [3:0]        State
);

   state_e               state_q;
   logic [FLAGS_W-1:0]   flags_q;
   logic                 condex_q;

   logic                 cond_ex;
   alu_dec_t             dec;
   logic [1:0]           op;
   logic [3:0]           rd;
   logic                 no_write;
   logic                 is_exec;
   logic                 nz_we;
   logic                 cv_we;

   logic                 is_fetch;
   logic                 ir_w;
   logic                 reg_w;
   logic                 mem_w;
   logic                 branch;
   logic                 pcs;
   logic                 adr_src;
   logic [1:0]           res_src;
   logic                 src_a;
   logic [1:0]           src_b;

   logic                 unused_instr;

   assign op       = Instr[27:26];
   assign rd       = Instr[15:12];
   assign dec      = alu_decode(Instr[24:21], Instr[20]);
   assign no_write = dec.no_write & (op == OP_DP);
   assign is_exec  = (state_q == S_EXECR) || (state_q == S_EXECI);
   assign nz_we    = is_exec & dec.flag_w[1] & condex_q;
   assign cv_we    = is_exec & dec.flag_w[0] & condex_q;

   assign unused_instr = ^{Instr[19:16], Instr[11:0]};

   cond_check u_cond_check (
      .cond_i    (Instr[31:28]),
      .nzcv_i    (flags_q),
      .cond_ex_o (cond_ex)
   );

   // Sequencer state, latched condition result and NZCV flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         flags_q  <= FLAG_RESET;
         condex_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH:  state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_DP:   state_q <= Instr[25] ? S_EXECI : S_EXECR;
                  OP_MEM:  state_q <= S_MEMADR;
                  OP_BR:   state_q <= S_BRANCH;
                  default: state_q <= S_FETCH;
               endcase
            end
            S_MEMADR: state_q <= Instr[20] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_q <= S_MEMWB;
            S_EXECR:  state_q <= S_ALUWB;
            S_EXECI:  state_q <= S_ALUWB;
            default:  state_q <= S_FETCH;
         endcase

         if (state_q == S_DECODE) condex_q <= cond_ex;
         if (nz_we) flags_q[3:2] <= ALUFlags[3:2];
         if (cv_we) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

   // Moore output decode from the current state
   always_comb begin
      is_fetch = 1'b0;
      ir_w     = 1'b0;
      reg_w    = 1'b0;
      mem_w    = 1'b0;
      branch   = 1'b0;
      adr_src  = 1'b0;
      res_src  = RES_ALUOUT;
      src_a    = 1'b0;
      src_b    = SRCB_RD2;
      case (state_q)
         S_FETCH: begin
            is_fetch = 1'b1;
            ir_w     = 1'b1;
            src_a    = 1'b1;
            src_b    = SRCB_FOUR;
            res_src  = RES_ALURESULT;
         end
         S_DECODE: begin
            src_a    = 1'b1;
            src_b    = SRCB_FOUR;
            res_src  = RES_ALURESULT;
         end
         S_MEMADR: src_b = SRCB_EXTIMM;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            res_src  = RES_DATA;
            reg_w    = 1'b1;
         end
         S_MEMWR: begin
            adr_src  = 1'b1;
            mem_w    = 1'b1;
         end
         S_EXECR:  src_b = SRCB_RD2;
         S_EXECI:  src_b = SRCB_EXTIMM;
         S_ALUWB:  reg_w = ~no_write;
         S_BRANCH: begin
            src_b    = SRCB_EXTIMM;
            res_src  = RES_ALURESULT;
            branch   = 1'b1;
         end
         default: ;
      endcase
   end

   // Writes that change PC: branches and data-processing/loads targeting R15
   assign pcs = branch | (reg_w & (rd == 4'hF) & ~no_write);

   // Enables are forced low asynchronously while reset is held
   assign PCWrite  = ~reset & (is_fetch | (pcs & condex_q));
   assign IRWrite  = ~reset & ir_w;
   assign RegWrite = ~reset & reg_w & condex_q;
   assign MemWrite = ~reset & mem_w & condex_q;

   assign AdrSrc     = adr_src;
   assign ResultSrc  = res_src;
   assign ALUSrcA    = src_a;
   assign ALUSrcB    = src_b;
   assign ALUControl = is_exec ? ALUC_W'(dec.alu_op) : ALUC_W'(ALU_ADD);
   assign ImmSrc     = op;
   assign RegSrc     = {(op == OP_MEM) & ~Instr[20], (op == OP_BR)};
   assign State      = state_q;

endmodule

// File: tb/tb_mc_controlunit.sv
// Directed bench for mc_controlunit: per-cycle vector table plus reset/decode sequences.
module tb_mc_controlunit;

   localparam int unsigned ALUC_W = 4;
   localparam logic [3:0]  FRST   = 4'b0100;

   localparam logic [31:0] I_ADD    = 32'hE0821003;
   localparam logic [31:0] I_SUBS   = 32'hE0500000;
   localparam logic [31:0] I_ADDEQ  = 32'h02811001;
   localparam logic [31:0] I_ADDNE  = 32'h12811001;
   localparam logic [31:0] I_ADDS   = 32'hE0922002;
   localparam logic [31:0] I_CMP    = 32'hE1510001;
   localparam logic [31:0] I_ANDS   = 32'hE0100000;
   localparam logic [31:0] I_LDR    = 32'hE5954008;
   localparam logic [31:0] I_STR    = 32'hE5854008;
   localparam logic [31:0] I_BNE    = 32'h1A000002;
   localparam logic [31:0] I_ADDPC  = 32'hE08FF000;
   localparam logic [31:0] I_OP11   = 32'hEC000000;
   localparam logic [31:0] I_ADDNV  = 32'hF0821003;
   localparam logic [31:0] I_SUBSEQ = 32'h02500001;
   localparam logic [31:0] I_ADDSEQ = 32'h00922002;

   logic              clk;
   logic              reset;
   logic [31:0]       Instr;
   logic [3:0]        ALUFlags;
   logic              PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]        ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [ALUC_W-1:0] ALUControl;
   logic [3:0]        State;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  fin;
      logic [3:0]  st;
      logic        pcw;
      logic        rw;
      logic        mw;
      logic [2:0]  aluc;
      logic [3:0]  nzcv;
   } row_t;

   row_t rows[$];

   mc_controlunit #(.ALUC_W(ALUC_W), .FLAG_RESET(FRST)) dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .State      (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Ungated per-state outputs: {AdrSrc, IRWrite, ResultSrc, ALUSrcA, ALUSrcB}
   function automatic logic [6:0] moore(input logic [3:0] st);
      case (st)
         4'd0:    return 7'b0_1_10_1_10;
         4'd1:    return 7'b0_0_10_1_10;
         4'd2:    return 7'b0_0_00_0_01;
         4'd3:    return 7'b1_0_00_0_00;
         4'd4:    return 7'b0_0_01_0_00;
         4'd5:    return 7'b1_0_00_0_00;
         4'd6:    return 7'b0_0_00_0_00;
         4'd7:    return 7'b0_0_00_0_01;
         4'd8:    return 7'b0_0_00_0_00;
         4'd9:    return 7'b0_0_10_0_01;
         default: return 7'b0;
      endcase
   endfunction

   task automatic add(input logic [31:0] in, input logic [3:0] fin, input logic [3:0] st,
                      input logic pcw, input logic rw, input logic mw,
                      input logic [2:0] aluc, input logic [3:0] nz);
      row_t r;
      r.instr = in; r.fin = fin; r.st = st; r.pcw = pcw;
      r.rw = rw; r.mw = mw; r.aluc = aluc; r.nzcv = nz;
      rows.push_back(r);
   endtask

   // FETCH and DECODE rows common to every instruction
   task automatic fd(input logic [31:0] in, input logic [3:0] nz);
      add(in, 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 3'b000, nz);
      add(in, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000, nz);
   endtask

   initial begin
      logic [6:0]  m;
      logic [31:0] act, exp;
      row_t        r;

      // ---- table of expected per-cycle outputs ----
      fd(I_ADD, 4'b0100);
      add(I_ADD,    4'b1111, 4'd6, 0, 0, 0, 3'b000, 4'b0100);
      add(I_ADD,    4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0100);
      fd(I_SUBS, 4'b0100);
      add(I_SUBS,   4'b0110, 4'd6, 0, 0, 0, 3'b001, 4'b0100);
      add(I_SUBS,   4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0110);
      fd(I_ADDEQ, 4'b0110);
      add(I_ADDEQ,  4'b0000, 4'd7, 0, 0, 0, 3'b000, 4'b0110);
      add(I_ADDEQ,  4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0110);
      fd(I_ADDNE, 4'b0110);
      add(I_ADDNE,  4'b0000, 4'd7, 0, 0, 0, 3'b000, 4'b0110);
      add(I_ADDNE,  4'b0000, 4'd8, 0, 0, 0, 3'b000, 4'b0110);
      fd(I_ADDS, 4'b0110);
      add(I_ADDS,   4'b1000, 4'd6, 0, 0, 0, 3'b000, 4'b0110);
      add(I_ADDS,   4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b1000);
      fd(I_CMP, 4'b1000);
      add(I_CMP,    4'b0110, 4'd6, 0, 0, 0, 3'b001, 4'b1000);
      add(I_CMP,    4'b0000, 4'd8, 0, 0, 0, 3'b000, 4'b0110);
      fd(I_ANDS, 4'b0110);
      add(I_ANDS,   4'b1001, 4'd6, 0, 0, 0, 3'b010, 4'b0110);
      add(I_ANDS,   4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b1010);
      fd(I_LDR, 4'b1010);
      add(I_LDR,    4'b0000, 4'd2, 0, 0, 0, 3'b000, 4'b1010);
      add(I_LDR,    4'b0000, 4'd3, 0, 0, 0, 3'b000, 4'b1010);
      add(I_LDR,    4'b0000, 4'd4, 0, 1, 0, 3'b000, 4'b1010);
      fd(I_STR, 4'b1010);
      add(I_STR,    4'b0000, 4'd2, 0, 0, 0, 3'b000, 4'b1010);
      add(I_STR,    4'b0000, 4'd5, 0, 0, 1, 3'b000, 4'b1010);
      fd(I_BNE, 4'b1010);
      add(I_BNE,    4'b0000, 4'd9, 1, 0, 0, 3'b000, 4'b1010);
      fd(I_SUBS, 4'b1010);
      add(I_SUBS,   4'b0110, 4'd6, 0, 0, 0, 3'b001, 4'b1010);
      add(I_SUBS,   4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0110);
      fd(I_BNE, 4'b0110);
      add(I_BNE,    4'b0000, 4'd9, 0, 0, 0, 3'b000, 4'b0110);
      fd(I_ADDPC, 4'b0110);
      add(I_ADDPC,  4'b0000, 4'd6, 0, 0, 0, 3'b000, 4'b0110);
      add(I_ADDPC,  4'b0000, 4'd8, 1, 1, 0, 3'b000, 4'b0110);
      fd(I_OP11, 4'b0110);
      fd(I_ADDNV, 4'b0110);
      add(I_ADDNV,  4'b0000, 4'd6, 0, 0, 0, 3'b000, 4'b0110);
      add(I_ADDNV,  4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0110);
      fd(I_SUBSEQ, 4'b0110);
      add(I_SUBSEQ, 4'b0010, 4'd7, 0, 0, 0, 3'b001, 4'b0110);
      add(I_SUBSEQ, 4'b0000, 4'd8, 0, 1, 0, 3'b000, 4'b0010);
      fd(I_ADDSEQ, 4'b0010);
      add(I_ADDSEQ, 4'b1111, 4'd6, 0, 0, 0, 3'b000, 4'b0010);
      add(I_ADDSEQ, 4'b0000, 4'd8, 0, 0, 0, 3'b000, 4'b0010);

      // ---- reset held: enables low, FETCH selects visible ----
      reset    = 1'b1;
      Instr    = I_ADD;
      ALUFlags = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_hold_state", 32'(State), 32'd0);
      check("rst_hold_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'h0);
      check("rst_hold_nzcv", 32'(dut.flags_q), 32'(FRST));
      @(negedge clk);
      reset = 1'b0;

      // ---- table replay, one row per clock ----
      for (int i = 0; i < rows.size(); i++) begin
         r        = rows[i];
         Instr    = r.instr;
         ALUFlags = r.fin;
         #1;
         m   = moore(r.st);
         act = 32'({State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUControl, dut.flags_q});
         exp = 32'({r.st, r.pcw, m[6], r.mw, m[5], r.rw,
                    m[4:3], m[2], m[1:0], {1'b0, r.aluc}, r.nzcv});
         check($sformatf("row%0d_st%0d", i, r.st), act, exp);
         @(negedge clk);
      end

      // ---- asynchronous reset in the middle of a store ----
      Instr    = I_STR;
      ALUFlags = 4'b0000;
      repeat (3) @(negedge clk);
      #1;
      check("memwr_state", 32'(State), 32'd5);
      check("memwr_memwrite", 32'(MemWrite), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst_async_memwrite", 32'(MemWrite), 32'd0);
      check("rst_async_state", 32'(State), 32'd0);
      check("rst_async_enables", 32'({PCWrite, IRWrite, RegWrite}), 32'h0);
      check("rst_async_fetch_sel", 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}), 32'b0_10_1_10);
      check("rst_async_nzcv", 32'(dut.flags_q), 32'(FRST));
      check("rst_async_condex", 32'(dut.condex_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_state", 32'(State), 32'd0);
      check("rel_irwrite", 32'(IRWrite), 32'd1);
      check("rel_pcwrite", 32'(PCWrite), 32'd1);
      @(posedge clk);
      #1;
      check("rel_next_state", 32'(State), 32'd1);

      // ---- Instr-derived ImmSrc / RegSrc ----
      Instr = I_STR;
      #1;
      check("str_immsrc_regsrc", 32'({ImmSrc, RegSrc}), 32'b01_10);
      Instr = I_LDR;
      #1;
      check("ldr_immsrc_regsrc", 32'({ImmSrc, RegSrc}), 32'b01_00);
      Instr = I_BNE;
      #1;
      check("b_immsrc_regsrc", 32'({ImmSrc, RegSrc}), 32'b10_01);
      Instr = I_ADDEQ;
      #1;
      check("dp_immsrc_regsrc", 32'({ImmSrc, RegSrc}), 32'b00_00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
